// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the PE input-activation path: default geometry and
// bitwidth constants, derived width helpers, and the compressor state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package pe_pkg;

    localparam int IA_ROW_DEF           = 8;
    localparam int IA_COL_DEF           = 8;
    localparam int IA_CHANNEL_DEF       = 8;
    localparam int IA_DATA_BITWIDTH_DEF = 8;
    localparam int IA_C_BITWIDTH_DEF    = $clog2(IA_CHANNEL_DEF);
    localparam int PE_LANES_DEF         = 1;

    // len/iters must represent 0..depth inclusive, hence the extra bit.
    localparam int IA_LEN_BITWIDTH_DEF  = $clog2(IA_CHANNEL_DEF) + 1;
    localparam int IA_H_BITWIDTH_DEF    = $clog2(IA_ROW_DEF) + 1;
    localparam int IA_W_BITWIDTH_DEF    = $clog2(IA_COL_DEF) + 1;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        START    = 2'd1,
        WAIT_FIN = 2'd2
    } ia_comp_state_e;

    // Width of a counter that must hold the values 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ia_pos_counter.sv
// -----------------------------------------------------------------------------
// ia_pos_counter
// Raster-order (h, w) pixel position counter, w fastest. Each i_advance moves
// to the next pixel; after (ROWS-1, COLS-1) it wraps to (0, 0) and pulses
// o_frame_done for one cycle (registered, so it appears the cycle after the
// advance). Reusable by the output writer.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_advance    step to the next pixel
//   o_h          current row
//   o_w          current column
//   o_frame_done one-cycle pulse after the frame's last pixel advances
// -----------------------------------------------------------------------------
module ia_pos_counter #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int H_W  = $clog2(ROWS) + 1,
    parameter int W_W  = $clog2(COLS) + 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_advance,
    output logic [H_W-1:0] o_h,
    output logic [W_W-1:0] o_w,
    output logic           o_frame_done
);

    logic [H_W-1:0] h_reg;
    logic [W_W-1:0] w_reg;
    logic           frame_done_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_reg          <= '0;
            w_reg          <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (i_advance) begin
                if (w_reg == W_W'(COLS - 1)) begin
                    w_reg <= '0;
                    if (h_reg == H_W'(ROWS - 1)) begin
                        h_reg          <= '0;
                        frame_done_reg <= 1'b1;
                    end else begin
                        h_reg <= h_reg + H_W'(1);
                    end
                end else begin
                    w_reg <= w_reg + W_W'(1);
                end
            end
        end
    end

    assign o_h          = h_reg;
    assign o_w          = w_reg;
    assign o_frame_done = frame_done_reg;

endmodule

// File: rtl/ia_compressor.sv
// -----------------------------------------------------------------------------
// ia_compressor
// Producer side of the PE's compressed input-activation bundle. Takes a dense,
// channel-minor activation stream (one value per cycle), packs each pixel's
// nonzero values and their channel indices, launches the PE with a one-cycle
// o_start and holds the bundle stable until i_finish.
//
// Optional feature: define IA_SKIP_EMPTY_EN to let an all-zero pixel bypass
// START/WAIT_FIN (position advances on the last beat, collection continues the
// next cycle). Without it an empty pixel launches the PE with len = 0.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid, i_data       dense activation stream (signed)
//   o_ready               stream ready (high only while collecting)
//   o_start               one-cycle PE launch pulse
//   i_finish              PE done with the current bundle
//   o_ia_h, o_ia_w        pixel position of the bundle
//   o_ia_data, o_ia_c_idx packed nonzeros and their channels (unused = 0)
//   o_ia_len, o_ia_iters  nonzero count and ceil(len / PE_LANES)
//   o_frame_done          pulse after the last pixel of a frame completes
// -----------------------------------------------------------------------------
module ia_compressor
    import pe_pkg::*;
#(
    parameter int IA_ROW           = IA_ROW_DEF,
    parameter int IA_COL           = IA_COL_DEF,
    parameter int IA_CHANNEL       = IA_CHANNEL_DEF,
    parameter int IA_DATA_BITWIDTH = IA_DATA_BITWIDTH_DEF,
    parameter int IA_C_BITWIDTH    = $clog2(IA_CHANNEL),
    parameter int PE_LANES         = PE_LANES_DEF
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_valid,
    input  logic signed [IA_DATA_BITWIDTH-1:0] i_data,
    output logic                               o_ready,
    output logic                               o_start,
    input  logic                               i_finish,
    output logic [$clog2(IA_ROW):0]            o_ia_h,
    output logic [$clog2(IA_COL):0]            o_ia_w,
    output logic signed [IA_DATA_BITWIDTH-1:0] o_ia_data  [0:IA_CHANNEL-1],
    output logic [IA_C_BITWIDTH-1:0]           o_ia_c_idx [0:IA_CHANNEL-1],
    output logic [$clog2(IA_CHANNEL):0]        o_ia_len,
    output logic [$clog2(IA_CHANNEL):0]        o_ia_iters,
    output logic                               o_frame_done
);

    localparam int LEN_W = count_width(IA_CHANNEL);
    localparam int H_W   = count_width(IA_ROW);
    localparam int W_W   = count_width(IA_COL);
    localparam logic [IA_C_BITWIDTH-1:0] LAST_CH = IA_C_BITWIDTH'(IA_CHANNEL - 1);

    ia_comp_state_e           state_reg, state_next;
    logic                     run_reg;
    logic [IA_C_BITWIDTH-1:0] ch_reg, ch_next;
    logic [LEN_W-1:0]         len_reg, len_next;

    logic beat_nz;
    logic clear_bundle;
    logic advance;

    // run_reg keeps o_ready low while in reset and goes high on the first
    // clock after release; it never drops again until the next reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= COLLECT;
            run_reg   <= 1'b0;
            ch_reg    <= '0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;
            ch_reg    <= ch_next;
            len_reg   <= len_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ch_next      = ch_reg;
        len_next     = len_reg;
        beat_nz      = 1'b0;
        clear_bundle = 1'b0;
        advance      = 1'b0;
        o_ready      = 1'b0;
        o_start      = 1'b0;

        unique case (state_reg)
            COLLECT: begin
                o_ready = run_reg;
                if (i_valid && run_reg) begin
                    beat_nz = (i_data != '0);
                    ch_next = ch_reg + IA_C_BITWIDTH'(1);
                    if (beat_nz) begin
                        len_next = len_reg + LEN_W'(1);
                    end
                    if (ch_reg == LAST_CH) begin
                        // Explicit wrap: for non power-of-two depths the
                        // increment would not return to zero on its own.
                        ch_next = '0;
`ifdef IA_SKIP_EMPTY_EN
                        if (!beat_nz && (len_reg == '0)) begin
                            advance = 1'b1;
                        end else begin
                            state_next = START;
                        end
`else
                        state_next = START;
`endif
                    end
                end
            end

            START: begin
                o_start    = 1'b1;
                state_next = WAIT_FIN;
            end

            WAIT_FIN: begin
                if (i_finish) begin
                    clear_bundle = 1'b1;
                    advance      = 1'b1;
                    len_next     = '0;
                    ch_next      = '0;
                    state_next   = COLLECT;
                end
            end

            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    // Bundle storage: one register pair per slot. Each slot is written only
    // by the nonzero beat that finds len pointing at it, so packing order
    // follows channel order. Slots are cleared together when the PE finishes,
    // which keeps every slot at index >= len reading zero.
    genvar gi;
    generate
        for (gi = 0; gi < IA_CHANNEL; gi++) begin : g_slot
            logic signed [IA_DATA_BITWIDTH-1:0] data_reg;
            logic [IA_C_BITWIDTH-1:0]           c_idx_reg;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    data_reg  <= '0;
                    c_idx_reg <= '0;
                end else if (clear_bundle) begin
                    data_reg  <= '0;
                    c_idx_reg <= '0;
                end else if (beat_nz && (len_reg == LEN_W'(gi))) begin
                    data_reg  <= i_data;
                    c_idx_reg <= ch_reg;
                end
            end

            assign o_ia_data[gi]  = data_reg;
            assign o_ia_c_idx[gi] = c_idx_reg;
        end
    endgenerate

    ia_pos_counter #(
        .ROWS (IA_ROW),
        .COLS (IA_COL),
        .H_W  (H_W),
        .W_W  (W_W)
    ) u_pos (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_advance    (advance),
        .o_h          (o_ia_h),
        .o_w          (o_ia_w),
        .o_frame_done (o_frame_done)
    );

    assign o_ia_len   = len_reg;
    assign o_ia_iters = LEN_W'((int'(len_reg) + PE_LANES - 1) / PE_LANES);

endmodule

// File: tb/tb_ia_compressor.sv
// -----------------------------------------------------------------------------
// tb_ia_compressor
// Directed, table-driven bench for ia_compressor configured as a 2x2 frame of
// 8-channel pixels with PE_LANES = 2. Each table row is one pixel's dense
// stream plus the expected packed bundle; hand-written sequences cover the
// handshake hold, empty pixel, frame wrap and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_ia_compressor;

    localparam int C = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              valid;
    logic signed [7:0] din;
    logic              finish;
    logic              ready;
    logic              start;
    logic [1:0]        ia_h;
    logic [1:0]        ia_w;
    logic signed [7:0] ia_data  [0:C-1];
    logic [2:0]        ia_c_idx [0:C-1];
    logic [3:0]        ia_len;
    logic [3:0]        ia_iters;
    logic              frame_done;

    ia_compressor #(
        .IA_ROW           (2),
        .IA_COL           (2),
        .IA_CHANNEL       (C),
        .IA_DATA_BITWIDTH (8),
        .IA_C_BITWIDTH    (3),
        .PE_LANES         (2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (valid),
        .i_data       (din),
        .o_ready      (ready),
        .o_start      (start),
        .i_finish     (finish),
        .o_ia_h       (ia_h),
        .o_ia_w       (ia_w),
        .o_ia_data    (ia_data),
        .o_ia_c_idx   (ia_c_idx),
        .o_ia_len     (ia_len),
        .o_ia_iters   (ia_iters),
        .o_frame_done (frame_done)
    );

    typedef struct {
        logic [0:C-1][7:0] vals;
        logic [0:C-1][7:0] exp_data;
        logic [0:C-1][2:0] exp_idx;
        logic [3:0]        exp_len;
        logic [3:0]        exp_iters;
    } vec_t;

    vec_t vecs [5];
    int   vec_count  = 0;
    int   miss_count = 0;
    int   exp_h = 0;
    int   exp_w = 0;
    logic exp_fd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [0:C-1][7:0] packed_data();
        logic [0:C-1][7:0] r;
        for (int i = 0; i < C; i++) r[i] = ia_data[i];
        return r;
    endfunction

    function automatic logic [0:C-1][2:0] packed_idx();
        logic [0:C-1][2:0] r;
        for (int i = 0; i < C; i++) r[i] = ia_c_idx[i];
        return r;
    endfunction

    task automatic adv_pos();
        if (exp_w == 1) begin
            exp_w = 0;
            exp_h = (exp_h == 1) ? 0 : exp_h + 1;
        end else begin
            exp_w = exp_w + 1;
        end
    endtask

    // Drives eight beats on consecutive cycles; returns at the negedge of the
    // cycle right after the last beat was accepted (where o_start is due).
    task automatic send_pixel(input logic [0:C-1][7:0] vals);
        for (int c = 0; c < C; c++) begin
            @(negedge clk);
            if (c == 0) chk("ready_before_pixel", 64'(ready), 64'd1);
            valid = 1'b1;
            din   = vals[c];
        end
        @(negedge clk);
        valid = 1'b0;
        din   = '0;
    endtask

    // Holds the bundle through START and a 5-cycle PE latency with i_valid
    // asserted, then finishes and checks the clear and position advance.
    task automatic finish_pixel(input logic [3:0] held_len, input logic [0:C-1][7:0] held_data);
        finish = 1'b1;             // sampled during START: must be ignored
        valid  = 1'b1;
        din    = 8'sh55;
        @(negedge clk);
        finish = 1'b0;
        chk("start_one_cycle", 64'(start), 64'd0);
        repeat (5) @(negedge clk);
        chk("ready_low_wait", 64'(ready), 64'd0);
        chk("len_held", 64'(ia_len), 64'(held_len));
        chk("data_held", 64'(packed_data()), 64'(held_data));
        exp_fd = (exp_h == 1) && (exp_w == 1);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        valid  = 1'b0;
        din    = '0;
        adv_pos();
        chk("ready_after_fin", 64'(ready), 64'd1);
        chk("len_cleared", 64'(ia_len), 64'd0);
        chk("iters_cleared", 64'(ia_iters), 64'd0);
        chk("data_cleared", 64'(packed_data()), 64'd0);
        chk("idx_cleared", 64'(packed_idx()), 64'd0);
        chk("frame_done", 64'(frame_done), 64'(exp_fd));
        chk("pos_h", 64'(ia_h), 64'(exp_h));
        chk("pos_w", 64'(ia_w), 64'(exp_w));
        @(negedge clk);
        chk("frame_done_drop", 64'(frame_done), 64'd0);
    endtask

    task automatic check_bundle(input vec_t v);
        chk("start_pulse", 64'(start), 64'd1);
        chk("ready_low_start", 64'(ready), 64'd0);
        chk("bundle_data", 64'(packed_data()), 64'(v.exp_data));
        chk("bundle_idx", 64'(packed_idx()), 64'(v.exp_idx));
        chk("bundle_len", 64'(ia_len), 64'(v.exp_len));
        chk("bundle_iters", 64'(ia_iters), 64'(v.exp_iters));
        chk("bundle_h", 64'(ia_h), 64'(exp_h));
        chk("bundle_w", 64'(ia_w), 64'(exp_w));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Mixed pixel: 0,5,0,0,-3,0,7,0 -> 3 nonzeros, 2 lanes -> 2 iters
        vecs[0].vals      = {8'd0, 8'd5, 8'd0, 8'd0, 8'hFD, 8'd0, 8'd7, 8'd0};
        vecs[0].exp_data  = {8'd5, 8'hFD, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[0].exp_idx   = {3'd1, 3'd4, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        vecs[0].exp_len   = 4'd3;
        vecs[0].exp_iters = 4'd2;
        // All channels nonzero, including the most-negative value
        vecs[1].vals      = {8'd1, 8'd2, 8'd3, 8'h80, 8'd5, 8'd6, 8'd7, 8'd8};
        vecs[1].exp_data  = {8'd1, 8'd2, 8'd3, 8'h80, 8'd5, 8'd6, 8'd7, 8'd8};
        vecs[1].exp_idx   = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        vecs[1].exp_len   = 4'd8;
        vecs[1].exp_iters = 4'd4;
        // Only the last channel nonzero
        vecs[2].vals      = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFF};
        vecs[2].exp_data  = {8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[2].exp_idx   = {3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        vecs[2].exp_len   = 4'd1;
        vecs[2].exp_iters = 4'd1;
        // Only the first channel nonzero
        vecs[3].vals      = {8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[3].exp_data  = {8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[3].exp_idx   = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        vecs[3].exp_len   = 4'd1;
        vecs[3].exp_iters = 4'd1;
        // Odd channels nonzero
        vecs[4].vals      = {8'd0, 8'd1, 8'd0, 8'd2, 8'd0, 8'd3, 8'd0, 8'd4};
        vecs[4].exp_data  = {8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[4].exp_idx   = {3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0};
        vecs[4].exp_len   = 4'd4;
        vecs[4].exp_iters = 4'd2;

        rst_n  = 1'b0;
        valid  = 1'b0;
        finish = 1'b0;
        din    = '0;
        #2;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_len", 64'(ia_len), 64'd0);
        chk("rst_pos", 64'({ia_h, ia_w}), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(ready), 64'd1);

        // Five pixels walk through (0,0),(0,1),(1,0),(1,1) and back to (0,0).
        for (int v = 0; v < 5; v++) begin
            send_pixel(vecs[v].vals);
            check_bundle(vecs[v]);
            finish_pixel(vecs[v].exp_len, vecs[v].exp_data);
        end

        // Empty pixel at (0,1)
        send_pixel('0);
`ifdef IA_SKIP_EMPTY_EN
        chk("empty_no_start", 64'(start), 64'd0);
        chk("empty_ready", 64'(ready), 64'd1);
        adv_pos();
        chk("empty_pos_w", 64'(ia_w), 64'(exp_w));
        chk("empty_pos_h", 64'(ia_h), 64'(exp_h));
`else
        chk("empty_start", 64'(start), 64'd1);
        chk("empty_len", 64'(ia_len), 64'd0);
        chk("empty_iters", 64'(ia_iters), 64'd0);
        finish_pixel(4'd0, '0);
`endif

        // Reset while the PE is busy with a bundle.
        send_pixel(vecs[0].vals);
        check_bundle(vecs[0]);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(ready), 64'd0);
        chk("midrst_start", 64'(start), 64'd0);
        chk("midrst_len", 64'(ia_len), 64'd0);
        chk("midrst_iters", 64'(ia_iters), 64'd0);
        chk("midrst_data", 64'(packed_data()), 64'd0);
        chk("midrst_idx", 64'(packed_idx()), 64'd0);
        chk("midrst_pos", 64'({ia_h, ia_w}), 64'd0);
        chk("midrst_frame_done", 64'(frame_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_h = 0;
        exp_w = 0;
        @(negedge clk);
        chk("ready_after_midrst", 64'(ready), 64'd1);
        send_pixel(vecs[3].vals);    // nonzero at channel 0 proves ch restarted at 0
        check_bundle(vecs[3]);
        finish_pixel(vecs[3].exp_len, vecs[3].exp_data);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
